// File: rtl/fetch_pc_gen.sv
// Fetch next-PC stage: holds the fetch PC, predicts the next PC from the BTB and a
// 2-bit BHT, registers the IF/ID latch and redirects on EXE-resolved mispredicts.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16,
    parameter int          BHT_IDXW    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        btb_hit,
    input  logic [31:0] btb_addr,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_pred_taken,
    input  logic [31:0] br_pred_target,
    output logic [31:0] pc,
    output logic [31:0] pc_if2id,
    output logic        valid_if2id,
    output logic        pred_taken_if2id,
    output logic [31:0] pred_target_if2id,
    output logic        flush,
    output logic        btb_wr_en
);

    logic [1:0]          bht [BHT_ENTRIES];
    logic [BHT_IDXW-1:0] rd_idx;
    logic [BHT_IDXW-1:0] wr_idx;
    logic                pred;
    logic [31:0]         npc_pred;
    logic                mis;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    // IF: direction prediction gates the BTB hit
    always_comb begin
        rd_idx   = pc[BHT_IDXW+1:2];
        wr_idx   = br_pc[BHT_IDXW+1:2];
        pred     = btb_hit & bht[rd_idx][1];
        npc_pred = pred ? btb_addr : pc + 32'd4;
    end

    // A taken branch with the right direction but wrong target is still a mispredict
    always_comb begin
        mis       = br_valid & ((br_taken != br_pred_taken) |
                                (br_taken & br_pred_taken & (br_target != br_pred_target)));
        flush     = mis;
        btb_wr_en = br_valid & br_taken & mis;
    end

    // IF -> IF/ID boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc                <= RESET_PC;
            pc_if2id          <= 32'd0;
            valid_if2id       <= 1'b0;
            pred_taken_if2id  <= 1'b0;
            pred_target_if2id <= 32'd0;
        end else if (mis) begin
            pc                <= br_taken ? br_target : br_pc + 32'd4;
            pc_if2id          <= 32'd0;
            valid_if2id       <= 1'b0;
            pred_taken_if2id  <= 1'b0;
            pred_target_if2id <= 32'd0;
        end else if (!stall) begin
            pc                <= npc_pred;
            pc_if2id          <= pc;
            valid_if2id       <= 1'b1;
            pred_taken_if2id  <= pred;
            pred_target_if2id <= npc_pred;
        end
    end

    // Training ignores stall so a resolving branch is never lost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
        end else if (br_valid) begin
            bht[wr_idx] <= bht_next(bht[wr_idx], br_taken);
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: reset, prediction, training, mispredict redirect,
// stall priority, PC wrap, counter saturation and asynchronous reset.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        btb_hit;
    logic [31:0] btb_addr;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_pred_taken;
    logic [31:0] br_pred_target;
    logic [31:0] pc;
    logic [31:0] pc_if2id;
    logic        valid_if2id;
    logic        pred_taken_if2id;
    logic [31:0] pred_target_if2id;
    logic        flush;
    logic        btb_wr_en;

    int errors = 0;
    int checks = 0;

    fetch_pc_gen dut (
        .clk(clk), .rstn(rstn), .stall(stall), .btb_hit(btb_hit), .btb_addr(btb_addr),
        .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken), .br_target(br_target),
        .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
        .pc(pc), .pc_if2id(pc_if2id), .valid_if2id(valid_if2id),
        .pred_taken_if2id(pred_taken_if2id), .pred_target_if2id(pred_target_if2id),
        .flush(flush), .btb_wr_en(btb_wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic v, input logic [31:0] bpc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        br_valid = v; br_pc = bpc; br_taken = tk;
        br_target = tgt; br_pred_taken = ptk; br_pred_target = ptgt;
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; btb_hit = 1'b0; btb_addr = 32'd0;
        branch(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #3;
        chk32("rst_pc", pc, 32'h0);
        chk1("rst_valid", valid_if2id, 1'b0);
        chk32("rst_pc_if2id", pc_if2id, 32'h0);
        chk1("rst_pred", pred_taken_if2id, 1'b0);
        chk32("rst_ptgt", pred_target_if2id, 32'h0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_btbwr", btb_wr_en, 1'b0);
        #9 rstn = 1'b1;

        // Sequential fetch after reset release
        tick();
        chk32("seq_pc1", pc, 32'h4);
        chk32("seq_if2id1", pc_if2id, 32'h0);
        chk1("seq_valid1", valid_if2id, 1'b1);
        chk32("seq_ptgt1", pred_target_if2id, 32'h4);
        tick();
        chk32("seq_pc2", pc, 32'h8);
        chk32("seq_if2id2", pc_if2id, 32'h4);
        tick();
        chk32("seq_pc3", pc, 32'hC);
        tick();
        chk32("seq_pc4", pc, 32'h10);

        // BTB hit with an untrained (weakly not-taken) counter falls through
        btb_hit = 1'b1; btb_addr = 32'h80;
        tick();
        chk32("untrained_pc", pc, 32'h14);
        chk1("untrained_pred", pred_taken_if2id, 1'b0);
        chk32("untrained_ptgt", pred_target_if2id, 32'h14);
        btb_hit = 1'b0;

        // Train 0x10 taken four times while stalled; pipeline holds
        stall = 1'b1;
        branch(1'b1, 32'h10, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk1("train_flush", flush, 1'b0);
        chk1("train_btbwr", btb_wr_en, 1'b0);
        repeat (4) tick();
        chk32("stall_pc", pc, 32'h14);
        chk32("stall_if2id", pc_if2id, 32'h10);
        chk1("stall_valid", valid_if2id, 1'b1);

        // Not-taken mispredict during stall still redirects (to 0x0C+4)
        branch(1'b1, 32'h0C, 1'b0, 32'h0, 1'b1, 32'h0);
        #1;
        chk1("nt_mis_flush", flush, 1'b1);
        chk1("nt_mis_btbwr", btb_wr_en, 1'b0);
        tick();
        chk32("stall_mis_pc", pc, 32'h10);
        chk1("stall_mis_valid", valid_if2id, 1'b0);
        chk1("stall_mis_pred", pred_taken_if2id, 1'b0);
        branch(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        stall = 1'b0;

        // Trained counter now follows the BTB
        btb_hit = 1'b1; btb_addr = 32'h80;
        tick();
        chk32("trained_pc", pc, 32'h80);
        chk32("trained_if2id", pc_if2id, 32'h10);
        chk1("trained_pred", pred_taken_if2id, 1'b1);
        chk32("trained_ptgt", pred_target_if2id, 32'h80);
        btb_hit = 1'b0;

        // Taken mispredict
        branch(1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        chk1("tk_mis_flush", flush, 1'b1);
        chk1("tk_mis_btbwr", btb_wr_en, 1'b1);
        tick();
        chk32("tk_mis_pc", pc, 32'h100);
        chk1("tk_mis_valid", valid_if2id, 1'b0);
        branch(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        chk1("idle_flush", flush, 1'b0);
        tick();
        chk32("after_mis_pc", pc, 32'h104);
        chk32("after_mis_if2id", pc_if2id, 32'h100);
        chk1("after_mis_valid", valid_if2id, 1'b1);

        // Right direction, wrong target
        branch(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h300);
        #1;
        chk1("tgt_mis_flush", flush, 1'b1);
        chk1("tgt_mis_btbwr", btb_wr_en, 1'b1);
        tick();
        chk32("tgt_mis_pc", pc, 32'h200);

        // Not-taken mispredict resumes at br_pc+4
        branch(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        chk32("nt_mis_pc", pc, 32'h24);

        // PC wrap
        branch(1'b1, 32'h100, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        chk32("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        branch(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk32("wrap_pc", pc, 32'h0);
        chk32("wrap_if2id", pc_if2id, 32'hFFFF_FFFC);

        // Counter for 0x14 saturates at 00: three decrements, then one increment -> 01
        stall = 1'b1;
        branch(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) tick();
        branch(1'b1, 32'h14, 1'b1, 32'h0, 1'b1, 32'h0);
        tick();
        branch(1'b1, 32'h0, 1'b1, 32'h14, 1'b0, 32'h0);
        tick();
        chk32("sat_redirect_pc", pc, 32'h14);
        branch(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        stall = 1'b0;
        btb_hit = 1'b1; btb_addr = 32'h80;
        tick();
        chk32("sat_pc", pc, 32'h18);
        chk1("sat_pred", pred_taken_if2id, 1'b0);
        btb_hit = 1'b0;

        // Asynchronous reset mid-stream clears without a clock edge
        tick();
        #2 rstn = 1'b0;
        #1;
        chk32("arst_pc", pc, 32'h0);
        chk32("arst_if2id", pc_if2id, 32'h0);
        chk1("arst_valid", valid_if2id, 1'b0);
        chk1("arst_pred", pred_taken_if2id, 1'b0);
        #3 rstn = 1'b1;
        repeat (4) tick();
        chk32("arst_refetch_pc", pc, 32'h10);
        // Training on 0x10 must have been wiped back to weakly not-taken
        btb_hit = 1'b1; btb_addr = 32'h80;
        tick();
        chk32("arst_bht_pc", pc, 32'h14);
        btb_hit = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Instruction-fetch next-PC stage of the 4-stage branch-predicting pipeline.
- Holds the architectural fetch PC and presents it to the branch target buffer.
- Consumes the BTB hit/target and gates it with a 2-bit saturating direction table (BHT).
- Registers the fetch PC and prediction into the IF/ID latch, and redirects/flushes when EXE resolves a mispredicted branch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
BHT_ENTRIES, 16, number of 2-bit counters (power of 2, ≥2)
BHT_IDXW, 4, log2(BHT_ENTRIES); index = pc[BHT_IDXW+1:2]

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
stall  in  1  hazard stall from ID: hold PC and IF/ID latch
btb_hit  in  1  BTB hit for current pc
btb_addr  in  32  BTB predicted target for current pc
br_valid  in  1  a conditional branch is resolved in EXE this cycle
br_pc  in  32  PC of the resolving branch
br_taken  in  1  actual direction
br_target  in  32  actual taken target
br_pred_taken  in  1  prediction carried with that branch
br_pred_target  in  32  predicted target carried with that branch
pc  out  32  current fetch PC (to imem and BTB)
pc_if2id  out  32  registered fetch PC
valid_if2id  out  1  IF/ID latch holds a real instruction (0 = bubble)
pred_taken_if2id  out  1  registered prediction
pred_target_if2id  out  32  registered predicted target
flush  out  1  kill younger instructions (IF/ID and ID/EXE)
btb_wr_en  out  1  enable to BTB write port

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, pc_if2id=0, valid_if2id=0, pred_taken_if2id=0, pred_target_if2id=0, all BHT counters=2'b01 (weakly not-taken). flush and btb_wr_en are combinational and are 0 whenever br_valid=0. Reset mid-operation discards all in-flight state; first fetch after release is RESET_PC.
- Prediction (combinational, IF): idx=pc[BHT_IDXW+1:2]; pred = btb_hit & bht[idx][1]; npc_pred = pred ? btb_addr : pc+4. Addition is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Mispredict (combinational): mis = br_valid & ((br_taken != br_pred_taken) | (br_taken & br_pred_taken & (br_target != br_pred_target))). flush = mis. btb_wr_en = br_valid & br_taken & mis. The BTB computes its own write data.
- Next-state priority, per cycle:
  1. mis: pc <= br_taken ? br_target : br_pc+4; valid_if2id <= 0; IF/ID pc/pred fields don't-care (drive 0). Overrides stall.
  2. stall (no mis): pc and all IF/ID outputs hold.
  3. else: pc <= npc_pred; pc_if2id <= pc; valid_if2id <= 1; pred_taken_if2id <= pred; pred_target_if2id <= npc_pred.
- Latency: one cycle from pc to IF/ID outputs. Redirect target appears on pc the cycle after mis.
- BHT update: on br_valid (independent of stall), counter at br_pc[BHT_IDXW+1:2] increments if br_taken, else decrements, saturating at 2'b11 and 2'b00. A same-cycle read at an equal index uses the pre-update value.
- br_valid=0: no BHT change, flush=0, btb_wr_en=0.
- No internal FSM beyond the PC/latch registers and BHT. Exactly one redirect per mispredicted branch; no multi-cycle recovery.

Test Plan:
- Reset: rstn low then high, no stall, btb_hit=0 -> pc sequence 0,4,8,C; valid_if2id=0 in first cycle, 1 after; pc_if2id lags pc by 1.
- BTB hit, untrained: pc=0x10, btb_hit=1, btb_addr=0x80, counter 01 -> pred=0, next pc=0x14.
- Training: three br_valid taken updates for br_pc=0x10 -> counter 11 (fourth update stays 11). Refetch 0x10 with hit -> next pc=0x80, pred_taken_if2id=1, pred_target_if2id=0x80.
- Mispredict: br_valid, br_pc=0x20, br_taken=1, br_target=0x100, br_pred_taken=0 -> flush=1 and btb_wr_en=1 that cycle; next pc=0x100; valid_if2id=0. Not-taken mispredict (pred 1, actual 0) -> pc=0x24, btb_wr_en=0.
- Stall vs mispredict: stall=1 for 3 cycles -> pc and IF/ID hold. Assert mis during stall -> redirect happens anyway.
- Wrap/saturation: pc=0xFFFF_FFFC no hit -> next pc=0. Repeated not-taken updates keep counter at 00. Async reset asserted mid-stream -> outputs clear immediately, no clock needed.
